// File: rtl/event_packetizer_pkg.sv
// rtl/event_packetizer_pkg.sv - shared address widths, packet layout and marker filler for the event packetizer
package event_packetizer_pkg;

    localparam int x_width = 4;
    localparam int y_width = 4;
    localparam int TS_WIDTH_DEF = 16;

    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0] ts;
        logic [x_width-1:0]      x;
        logic [y_width-1:0]      y;
        logic                    pol;
    } event_pkt_t;

    // {x, y} filler carried by a timestamp-wrap marker packet
    localparam logic [x_width+y_width-1:0] MARKER_ADDR = '1;

    function automatic int pkt_width(input int ts_width);
        return ts_width + x_width + y_width + 1;
    endfunction

endpackage

// File: rtl/event_packetizer_if.sv
// rtl/event_packetizer_if.sv - event capture and packet readout handshake bundle
interface event_packetizer_if
    import event_packetizer_pkg::*;
#(
    parameter int PKT_W = pkt_width(TS_WIDTH_DEF)
);
    logic               evt_valid;
    logic [x_width-1:0] x_add;
    logic [y_width-1:0] y_add;
    logic               pol;
    logic               pkt_valid;
    logic               pkt_ready;
    logic [PKT_W-1:0]   pkt_data;

    modport slave (
        input  evt_valid, x_add, y_add, pol, pkt_ready,
        output pkt_valid, pkt_data
    );

    modport master (
        output evt_valid, x_add, y_add, pol, pkt_ready,
        input  pkt_valid, pkt_data
    );
endinterface

// File: rtl/event_packetizer_fifo.sv
// rtl/event_packetizer_fifo.sv - first-word-fall-through packet buffer (module event_fifo)
module event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a full buffer still accepts when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/event_packetizer.sv
// rtl/event_packetizer.sv - timestamps granted events into a buffered packet stream; TS_WRAP_MARKER_EN adds wrap markers
module event_packetizer
    import event_packetizer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16,
    parameter int OVF_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    event_packetizer_if.slave    bus,
    output logic                 fifo_full_o,
    output logic [OVF_WIDTH-1:0] ovf_cnt_o
);
    localparam int PKT_W = TS_WIDTH + x_width + y_width + 1;

    logic [TS_WIDTH-1:0]  ts_q;
    logic [OVF_WIDTH-1:0] ovf_q;
    logic                 fifo_empty;
    logic                 pop;
    logic                 evt_cap;
    logic                 push_req;
    logic                 room;
    logic                 push;
    logic                 evt_lost;
    logic [PKT_W-1:0]     push_data;
    logic [1:0]           drops;
    logic [OVF_WIDTH:0]   ovf_sum;

    assign pop     = bus.pkt_valid & bus.pkt_ready;
    assign evt_cap = bus.evt_valid & enable_i;

`ifdef TS_WRAP_MARKER_EN
    logic marker;
    // the marker takes the slot; a coincident event is lost
    assign marker    = enable_i & (&ts_q);
    assign push_req  = evt_cap | marker;
    assign evt_lost  = evt_cap & marker;
    assign push_data = marker ? {{TS_WIDTH{1'b0}}, MARKER_ADDR, 1'b0}
                              : {ts_q, bus.x_add, bus.y_add, bus.pol};
`else
    assign push_req  = evt_cap;
    assign evt_lost  = 1'b0;
    assign push_data = {ts_q, bus.x_add, bus.y_add, bus.pol};
`endif

    assign room    = ~fifo_full_o | pop;
    assign push    = push_req & room;
    assign drops   = {1'b0, push_req & ~room} + {1'b0, evt_lost};
    assign ovf_sum = {1'b0, ovf_q} + {{(OVF_WIDTH-1){1'b0}}, drops};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_q  <= '0;
            ovf_q <= '0;
        end else begin
            if (enable_i) ts_q <= ts_q + TS_WIDTH'(1);
            ovf_q <= ovf_sum[OVF_WIDTH] ? '1 : ovf_sum[OVF_WIDTH-1:0];
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .din     (push_data),
        .pop     (pop),
        .dout    (bus.pkt_data),
        .full    (fifo_full_o),
        .empty   (fifo_empty)
    );

    assign bus.pkt_valid = ~fifo_empty;
    assign ovf_cnt_o     = ovf_q;

endmodule

// File: tb/tb_event_packetizer.sv
// tb/tb_event_packetizer.sv - directed and randomized checks of event_packetizer against a queue model
module tb_event_packetizer;
    import event_packetizer_pkg::*;

    localparam int DEPTH = 8;
    localparam int XW = x_width;
    localparam int YW = y_width;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic enable_i = 1'b0;
    logic full_a, full_b;
    logic [7:0] ovf_a;
    logic [2:0] ovf_b;

    always #5 clk = ~clk;

    event_packetizer_if #(.PKT_W(pkt_width(16))) bus_a ();
    event_packetizer_if #(.PKT_W(pkt_width(4)))  bus_b ();

    event_packetizer #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(16), .OVF_WIDTH(8)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .bus(bus_a.slave),
        .fifo_full_o(full_a), .ovf_cnt_o(ovf_a));

    event_packetizer #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(4), .OVF_WIDTH(3)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .bus(bus_b.slave),
        .fifo_full_o(full_b), .ovf_cnt_o(ovf_b));

    int total = 0;
    int bad = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int mts[2];
    int movf[2];
    int tsw[2] = '{16, 4};
    int ovmax[2] = '{255, 7};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        mts = '{0, 0};
        movf = '{0, 0};
    endtask

    task automatic model_step(input int k, input bit en, input bit evt, input int x,
                              input int y, input bit pol, input bit rdy);
        logic [63:0] q[$];
        logic [63:0] pk;
        int tsmax, drops;
        bit have, popq, room;
        if (k == 0) q = q0; else q = q1;
        tsmax = (1 << tsw[k]) - 1;
        drops = 0;
        have = 0;
        pk = '0;
        popq = (q.size() > 0) && rdy;
        room = (q.size() < DEPTH) || popq;
`ifdef TS_WRAP_MARKER_EN
        if (en && mts[k] == tsmax) begin
            have = 1;
            pk = ((64'd1 << (XW + YW)) - 1) << 1;
            if (evt) drops++;
        end else
`endif
        if (en && evt) begin
            have = 1;
            pk = (64'(mts[k]) << (XW + YW + 1)) | (64'(x) << (YW + 1)) | (64'(y) << 1) | 64'(pol);
        end
        if (popq) void'(q.pop_front());
        if (have) begin
            if (room) q.push_back(pk);
            else drops++;
        end
        movf[k] = (movf[k] + drops > ovmax[k]) ? ovmax[k] : movf[k] + drops;
        if (en) mts[k] = (mts[k] + 1) & tsmax;
        if (k == 0) q0 = q; else q1 = q;
    endtask

    task automatic check_all(input string tag);
        logic [63:0] head;
        head = (q0.size() > 0) ? q0[0] : 64'd0;
        chk({tag, "_a_valid"}, 64'(bus_a.pkt_valid), 64'(q0.size() > 0));
        chk({tag, "_a_full"},  64'(full_a), 64'(q0.size() == DEPTH));
        chk({tag, "_a_ovf"},   64'(ovf_a), 64'(movf[0]));
        if (q0.size() > 0) chk({tag, "_a_data"}, 64'(bus_a.pkt_data), head);
        head = (q1.size() > 0) ? q1[0] : 64'd0;
        chk({tag, "_b_valid"}, 64'(bus_b.pkt_valid), 64'(q1.size() > 0));
        chk({tag, "_b_full"},  64'(full_b), 64'(q1.size() == DEPTH));
        chk({tag, "_b_ovf"},   64'(ovf_b), 64'(movf[1]));
        if (q1.size() > 0) chk({tag, "_b_data"}, 64'(bus_b.pkt_data), head);
    endtask

    task automatic step(input string tag, input bit en, input bit evt, input int x,
                        input int y, input bit pol, input bit rdy);
        enable_i = en;
        bus_a.evt_valid = evt; bus_b.evt_valid = evt;
        bus_a.x_add = XW'(x);  bus_b.x_add = XW'(x);
        bus_a.y_add = YW'(y);  bus_b.y_add = YW'(y);
        bus_a.pol = pol;       bus_b.pol = pol;
        bus_a.pkt_ready = rdy; bus_b.pkt_ready = rdy;
        @(posedge clk);
        model_step(0, en, evt, x, y, pol, rdy);
        model_step(1, en, evt, x, y, pol, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        enable_i = 1'b0;
        bus_a.evt_valid = 0; bus_b.evt_valid = 0;
        bus_a.pkt_ready = 0; bus_b.pkt_ready = 0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_a_data", 64'(bus_a.pkt_data), 64'd0);
        check_all("rst");
        reset_i = 1'b0;
    endtask

    initial begin
        event_pkt_t e;
        bus_a.x_add = '0; bus_b.x_add = '0;
        bus_a.y_add = '0; bus_b.y_add = '0;
        bus_a.pol = 0;    bus_b.pol = 0;
        do_reset();

        // 1: single event at ts=10
        for (int i = 0; i < 10; i++) step("t1_idle", 1, 0, 0, 0, 0, 1);
        step("t1_evt", 1, 1, 3, 5, 1, 1);
        e = '{ts: 16'd10, x: 4'd3, y: 4'd5, pol: 1'b1};
        chk("t1_data_const", 64'(bus_a.pkt_data), 64'(e));
        step("t1_after", 1, 0, 0, 0, 0, 1);
        chk("t1_valid_low", 64'(bus_a.pkt_valid), 64'd0);

        // 2: overflow with ready low, then drain
        for (int i = 0; i < 10; i++) step("t2_fill", 1, 1, i, 9 - i, i & 1, 0);
        chk("t2_full", 64'(full_a), 64'd1);
        chk("t2_ovf", 64'(ovf_a), 64'd2);
        // 3: full with simultaneous pop
        step("t3_pushpop", 1, 1, 7, 7, 0, 1);
        chk("t3_full", 64'(full_a), 64'd1);
        chk("t3_ovf", 64'(ovf_a), 64'd2);
        for (int i = 0; i < 3; i++) step("t2_drain", 1, 0, 0, 0, 0, 1);
        // 4: disabled with events asserted keeps draining, no capture
        for (int i = 0; i < 5; i++) step("t4_dis", 0, 1, 2, 2, 1, 1);
        step("t4_resume", 1, 1, 1, 1, 1, 0);

        // 6: asynchronous reset with packets queued
        for (int i = 0; i < 5; i++) step("t6_fill", 1, 1, i, i, 1, 0);
        @(negedge clk);
        #2 reset_i = 1'b1;
        #1;
        chk("t6_valid", 64'(bus_a.pkt_valid), 64'd0);
        chk("t6_ovf", 64'(ovf_a), 64'd0);
        chk("t6_data", 64'(bus_a.pkt_data), 64'd0);
        do_reset();
        step("t6_ts0", 1, 1, 6, 6, 0, 0);

        // 5: event in the 4-bit timestamp wrap cycle
        do_reset();
        for (int i = 0; i < 15; i++) step("t5_idle", 1, 0, 0, 0, 0, 0);
        step("t5_wrap", 1, 1, 3, 5, 1, 0);
`ifdef TS_WRAP_MARKER_EN
        chk("t5_marker", 64'(bus_b.pkt_data), 64'h1FE);
        chk("t5_ovf", 64'(ovf_b), 64'd1);
`else
        chk("t5_event", 64'(bus_b.pkt_data), 64'h1E6B);
        chk("t5_ovf", 64'(ovf_b), 64'd0);
`endif

        // randomized traffic, including overflow saturation on the narrow counter
        for (int i = 0; i < 600; i++)
            step("rand", ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < (i < 300 ? 3 : 6)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
